// File: rtl/periph_pkg.sv
// Shared constants for the peripheral register bank: register word offsets,
// CONTROL/STATUS bit positions and the default identification word.
package periph_pkg;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'h4C43_0001;

  // Word offsets, i.e. add_i[7:2]
  localparam logic [5:0] OFF_ID          = 6'h00;
  localparam logic [5:0] OFF_CONTROL     = 6'h01;
  localparam logic [5:0] OFF_STATUS      = 6'h02;
  localparam logic [5:0] OFF_CYCLE_LO    = 6'h03;
  localparam logic [5:0] OFF_CYCLE_HI    = 6'h04;
  localparam logic [5:0] OFF_TIMER_LOAD  = 6'h05;
  localparam logic [5:0] OFF_TIMER_VALUE = 6'h06;
  localparam logic [5:0] OFF_SCRATCH     = 6'h07;
  localparam logic [5:0] OFF_MAILBOX     = 6'h08;

  localparam int CTRL_CNT_EN    = 0;
  localparam int CTRL_CNT_CLR   = 1;
  localparam int CTRL_TMR_START = 2;

  localparam int ST_EXPIRED    = 0;
  localparam int ST_MBOX_EMPTY = 1;
  localparam int ST_MBOX_FULL  = 2;
  localparam int ST_MBOX_OVF   = 3;

endpackage

// File: rtl/mailbox_fifo.sv
// Power-of-two word FIFO for the processor-to-host mailbox. A push into a full
// FIFO is dropped and flagged, unless a pop frees the slot in the same cycle.
module mailbox_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             pop_ok_s;
  logic             push_ok_s;

  // Next-state: pop is evaluated first so a full FIFO can accept a same-cycle push
  always_comb begin
    pop_ok_s   = pop_i && (count_q != {CW{1'b0}});
    push_ok_s  = push_i && ((count_q != FULL_CNT) || pop_ok_s);
    overflow_o = push_i && !push_ok_s;
    mem_d      = mem_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_data_i;
    end else begin
      mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
    end
    wr_ptr_d = push_ok_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_ok_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    empty_d = (count_d == {CW{1'b0}});
    full_d  = (count_d == FULL_CNT);
  end

  // State registers
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign empty_o    = empty_q;
  assign full_o     = full_q;

endmodule

// File: rtl/peripheral_register_bank.sv
// Memory-mapped register bank on the controller's peripheral port: ID, cycle
// counter with coherent high-word snapshot, countdown timer, scratch, mailbox.
module peripheral_register_bank
  import periph_pkg::*;
#(
  parameter logic [31:0] ID_VALUE   = ID_VALUE_DEFAULT,
  parameter int          MBOX_DEPTH = 8
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        rw_i,
  input  logic [26:0] add_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        mbox_push_i,
  input  logic [31:0] mbox_data_i,
  output logic        mbox_full_o,
  output logic        timer_irq_o
);

  logic        req_q, req_d;
  logic [31:0] data_q, data_d;
  logic        cnt_en_q, cnt_en_d;
  logic [63:0] cnt_q, cnt_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;
  logic [31:0] timer_load_q, timer_load_d;
  logic [31:0] timer_value_q, timer_value_d;
  logic [31:0] scratch_q, scratch_d;
  logic        expired_q, expired_d;
  logic        ovf_q, ovf_d;

  logic [5:0]  off_s;
  logic        acc_s, wr_s, rd_s;
  logic        cnt_clr_s, tmr_start_s, expire_evt_s, pop_s;
  logic [31:0] rdata_s;
  logic [31:0] fifo_head_s;
  logic        fifo_empty_s, fifo_full_s, fifo_ovf_s;
  logic        unused_addr_s;

  assign unused_addr_s = ^{add_i[25:8], add_i[1:0]};

  mailbox_fifo #(
    .DEPTH (MBOX_DEPTH),
    .WIDTH (32)
  ) u_mailbox_fifo (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .push_i      (mbox_push_i),
    .push_data_i (mbox_data_i),
    .pop_i       (pop_s),
    .pop_data_o  (fifo_head_s),
    .empty_o     (fifo_empty_s),
    .full_o      (fifo_full_s),
    .overflow_o  (fifo_ovf_s)
  );

  // Access decode: one access per rising request edge inside the peripheral region
  always_comb begin
    off_s       = add_i[7:2];
    req_d       = req_i;
    acc_s       = req_i && !req_q && add_i[26];
    wr_s        = acc_s && rw_i;
    rd_s        = acc_s && !rw_i;
    cnt_clr_s   = wr_s && (off_s == OFF_CONTROL) && data_i[CTRL_CNT_CLR];
    tmr_start_s = wr_s && (off_s == OFF_CONTROL) && data_i[CTRL_TMR_START];
    pop_s       = rd_s && (off_s == OFF_MAILBOX);
  end

  // Read mux over current register state
  always_comb begin
    case (off_s)
      OFF_ID:          rdata_s = ID_VALUE;
      OFF_CONTROL:     rdata_s = {31'd0, cnt_en_q};
      OFF_STATUS:      rdata_s = {28'd0, ovf_q, fifo_full_s, fifo_empty_s, expired_q};
      OFF_CYCLE_LO:    rdata_s = cnt_q[31:0];
      OFF_CYCLE_HI:    rdata_s = hi_shadow_q;
      OFF_TIMER_LOAD:  rdata_s = timer_load_q;
      OFF_TIMER_VALUE: rdata_s = timer_value_q;
      OFF_SCRATCH:     rdata_s = scratch_q;
      OFF_MAILBOX:     rdata_s = fifo_empty_s ? 32'd0 : fifo_head_s;
      default:         rdata_s = 32'd0;
    endcase
  end

  // Register next-state: counter, timer, sticky flags and writable registers
  always_comb begin
    data_d       = rd_s ? rdata_s : data_q;
    cnt_en_d     = (wr_s && (off_s == OFF_CONTROL)) ? data_i[CTRL_CNT_EN] : cnt_en_q;
    timer_load_d = (wr_s && (off_s == OFF_TIMER_LOAD)) ? data_i : timer_load_q;
    scratch_d    = (wr_s && (off_s == OFF_SCRATCH)) ? data_i : scratch_q;
    hi_shadow_d  = (rd_s && (off_s == OFF_CYCLE_LO)) ? cnt_q[63:32] : hi_shadow_q;

    if (cnt_clr_s) begin
      cnt_d = 64'd0;
    end else if (cnt_en_q) begin
      cnt_d = cnt_q + 64'd1;
    end else begin
      cnt_d = cnt_q;
    end

    // A zero-length start expires immediately; a reload overrides a pending 1->0 step
    if (tmr_start_s) begin
      timer_value_d = timer_load_q;
      expire_evt_s  = (timer_load_q == 32'd0);
    end else if (timer_value_q != 32'd0) begin
      timer_value_d = timer_value_q - 32'd1;
      expire_evt_s  = (timer_value_q == 32'd1);
    end else begin
      timer_value_d = timer_value_q;
      expire_evt_s  = 1'b0;
    end

    if (expire_evt_s) begin
      expired_d = 1'b1;
    end else if (wr_s && (off_s == OFF_STATUS) && data_i[ST_EXPIRED]) begin
      expired_d = 1'b0;
    end else begin
      expired_d = expired_q;
    end

    if (fifo_ovf_s) begin
      ovf_d = 1'b1;
    end else if (wr_s && (off_s == OFF_STATUS) && data_i[ST_MBOX_OVF]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      req_q         <= 1'b0;
      data_q        <= 32'd0;
      cnt_en_q      <= 1'b0;
      cnt_q         <= 64'd0;
      hi_shadow_q   <= 32'd0;
      timer_load_q  <= 32'd0;
      timer_value_q <= 32'd0;
      scratch_q     <= 32'd0;
      expired_q     <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      req_q         <= req_d;
      data_q        <= data_d;
      cnt_en_q      <= cnt_en_d;
      cnt_q         <= cnt_d;
      hi_shadow_q   <= hi_shadow_d;
      timer_load_q  <= timer_load_d;
      timer_value_q <= timer_value_d;
      scratch_q     <= scratch_d;
      expired_q     <= expired_d;
      ovf_q         <= ovf_d;
    end
  end

  assign data_o      = data_q;
  assign timer_irq_o = expired_q;
  assign mbox_full_o = fifo_full_s;

endmodule

// File: doc/peripheral_register_bank.md
# peripheral_register_bank

Memory-mapped peripheral register bank on the comm-side peripheral port of the external memory controller; it consumes that controller's req2/rw2/add2/data2 outputs and drives its data2 input. Provides an ID word, a 64-bit cycle counter with coherent high-word snapshot, a one-shot countdown timer with sticky expiry interrupt, a scratch register, and a processor-fed mailbox FIFO that the host drains over JTAG. All register reads return registered data one cycle after the request edge, within the controller's two-cycle peripheral read window.

## Interface
- ID_VALUE, 32'h4C43_0001, constant returned by the ID register
- MBOX_DEPTH, 8, mailbox FIFO depth in words (power of two, ≥2)
- clock_i  in  1  system clock; the only clock
- reset_i  in  1  reset, synchronous, active-low (block resets on the clock_i edge where reset_i==0)
- req_i  in  1  peripheral request level from the controller; acted on at rising edge only
- rw_i  in  1  1 = write, 0 = read
- add_i  in  27  byte address; bit 26 = peripheral region, offset decoded from add_i[7:2]
- data_i  in  32  write data
- data_o  out  32  read data, registered, held until next read
- mbox_push_i  in  1  processor-side mailbox push strobe (one word per cycle high)
- mbox_data_i  in  32  mailbox push data
- mbox_full_o  out  1  mailbox full
- timer_irq_o  out  1  equals STATUS.expired

## Operation
- Access event: acc = req_i & ~req_q & add_i[26]; req_q registers req_i. Held requests produce exactly one access. add_i[26]==0 ignored.
- Register map (offset): 0x00 ID RO; 0x04 CONTROL RW; 0x08 STATUS RO/W1C; 0x0C CYCLE_LO RO; 0x10 CYCLE_HI RO; 0x14 TIMER_LOAD RW; 0x18 TIMER_VALUE RO; 0x1C SCRATCH RW; 0x20 MAILBOX RO-pop. Unmapped offsets: read 0, write ignored. Writes to RO registers ignored.
- CONTROL: bit0 cnt_en (RW); bit1 cnt_clr (write-1 pulse, reads 0); bit2 tmr_start (write-1 pulse, reads 0); bits 31:3 read 0.
- STATUS: bit0 expired (W1C), bit1 mbox_empty, bit2 mbox_full, bit3 mbox_overflow (W1C); others 0.
- Cycle counter: 64-bit, +1 per cycle while cnt_en, wraps 2^64-1→0. cnt_clr takes precedence over increment in its cycle. Reading CYCLE_LO returns live low word and copies live high word into hi_shadow in the same edge; CYCLE_HI returns hi_shadow.
- Timer: tmr_start loads TIMER_VALUE←TIMER_LOAD (restart while running reloads). While TIMER_VALUE≠0 it decrements by 1 per cycle; on 1→0 transition expired←1. Start with TIMER_LOAD==0: expired set the following cycle. Expiry event and W1C in the same cycle: set wins.
- Mailbox: FIFO of MAILBOX_DEPTH words. mbox_push_i when full: word dropped, mbox_overflow←1. Read of MAILBOX pops head; empty read returns 0, no state change. Simultaneous push and pop when full: both occur, no overflow. Pointers wrap modulo depth; occupancy count is clog2(depth)+1 bits.
- Reset values: data_o=0, timer_irq_o=0, mbox_full_o=0, CONTROL=0, STATUS flags=0, counter=0, hi_shadow=0, TIMER_LOAD=0, TIMER_VALUE=0, SCRATCH=0, FIFO empty, req_q=0. Reset mid-transaction discards the access and any FIFO contents.

## Timing
- Cycle N: rising req_i seen. Edge ending N: write committed or data_o loaded, pop executed. Cycle N+1: data_o valid and held until next read access.
- Write side effects (cnt_clr, tmr_start) visible in register state from N+1; counter counts from 0 at N+2 after clear.
- mbox_full_o, timer_irq_o registered; reflect state one cycle after the causing event.
- No back-pressure; one access per req_i rising edge, minimum two cycles between accesses.

## Structure
- Shared package periph_pkg: register offset constants, CONTROL/STATUS bit positions, default ID_VALUE.
- One sub-module: mailbox_fifo (push/pop/data/empty/full/overflow-on-push), parameterised by depth. Decode, counter, timer and read mux in the top module.

## Test plan
- After reset, read 0x00 → data_o=32'h4C43_0001 one cycle after req edge; hold req_i 5 cycles → only one access (FIFO pop count/side effects unchanged).
- Write CONTROL=1, wait 100 cycles, read CYCLE_LO then CYCLE_HI → LO≈100±2, HI=0; preset counter near 2^32-1, read LO then HI across carry → HI reflects snapshot taken at LO read.
- TIMER_LOAD=5, write CONTROL=4 → TIMER_VALUE 5,4,…,0; expired and timer_irq_o set 1 cycle after 0; W1C STATUS=1 → cleared; W1C on expiry cycle → stays 1.
- Push 8 words 0x10..0x17, push 0x18 → mbox_full_o=1, overflow=1; read MAILBOX 9× → 0x10..0x17 then 0; STATUS.mbox_empty=1.
- Full FIFO, push and pop same cycle → popped word returned, new word enqueued, overflow stays 0.
- Write SCRATCH=0xA5A5_5A5A with add_i[26]=0 → SCRATCH unchanged; with bit 26 set → readback 0xA5A5_5A5A; assert reset_i=0 → all outputs and registers return to reset values next edge.
